// File: rtl/pokey_bus_master.sv
// pokey_bus_master: bus initiator for the sound POKEY pair.
// Queues register read/write requests from a local sequencer and replays each one as a
// timed CPU-style I/O cycle (setup, CIOn strobe, hold) on BA/CIOn/BRWn/BD. Read data is
// captured from pokey_to_cpu at the end of the strobe and returned with a one-clock pulse.
// Optional feature: define POKEY_TXN_COUNT_EN to count completed transactions on txn_count;
// otherwise txn_count is tied to zero.
module pokey_bus_master #(
  parameter logic [15:0] IO_BASE    = 16'h9C00,  // bits [9:0] must be zero
  parameter int unsigned FIFO_DEPTH = 4,         // power of two, 2..16
  parameter int unsigned SETUP_CYC  = 1,         // 1..15
  parameter int unsigned STROBE_CYC = 2,         // 1..15
  parameter int unsigned HOLD_CYC   = 1          // 0..15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_chip,
  input  logic [3:0]  req_addr,
  input  logic [7:0]  req_data,
  input  logic [7:0]  pokey_to_cpu,
  output logic [15:0] BA,
  output logic        CIOn,
  output logic        BRWn,
  output logic [7:0]  BD,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic       we;
    logic       chip;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  // Request queue; the extra pointer bit separates full from empty.
  req_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  req_t          head;

  state_e        state;
  logic [3:0]    phase;
  logic          cyc_we;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req_ready  = ~fifo_full;
  assign push       = req_valid & req_ready;
  assign pop        = (state == StIdle) & ~fifo_empty;
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign busy       = ~fifo_empty | (state != StIdle);

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {req_we, req_chip, req_addr, req_data};
    end
  end

  // Queue pointers; reset flushes any pending requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Bus cycle sequencer; every bus-facing output is registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= StIdle;
      phase    <= '0;
      cyc_we   <= 1'b0;
      BA       <= IO_BASE;
      CIOn     <= 1'b1;
      BRWn     <= 1'b1;
      BD       <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (pop) begin
            BA     <= IO_BASE | {6'b0, head.chip, 5'b0, head.addr};
            BRWn   <= ~head.we;
            // Reads leave BD at its previous value.
            if (head.we) BD <= head.data;
            cyc_we <= head.we;
            phase  <= 4'(SETUP_CYC - 1);
            state  <= StSetup;
          end
        end
        StSetup: begin
          if (phase == '0) begin
            phase <= 4'(STROBE_CYC - 1);
            CIOn  <= 1'b0;
            state <= StStrobe;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        StStrobe: begin
          if (phase == '0) begin
            CIOn <= 1'b1;
            if (!cyc_we) begin
              rd_data  <= pokey_to_cpu;
              rd_valid <= 1'b1;
            end
            if (HOLD_CYC != 0) begin
              phase <= 4'(HOLD_CYC - 1);
              state <= StHold;
            end else begin
              BRWn  <= 1'b1;
              state <= StIdle;
            end
          end else begin
            phase <= phase - 4'd1;
          end
        end
        StHold: begin
          if (phase == '0) begin
            BRWn  <= 1'b1;
            state <= StIdle;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef POKEY_TXN_COUNT_EN
  logic        txn_done;
  logic [15:0] txn_q;

  // A transaction completes on the clock the sequencer returns to idle.
  assign txn_done = (phase == '0) &&
                    ((state == StHold) || ((state == StStrobe) && (HOLD_CYC == 0)));

  // Completed-transaction counter, wraps modulo 2^16.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_q <= '0;
    end else if (txn_done) begin
      txn_q <= txn_q + 16'd1;
    end
  end

  assign txn_count = txn_q;
`else
  assign txn_count = 16'h0000;
`endif

endmodule
